// File: rtl/fp_cmp_unit_pipelined.sv
// Pipelined FP compare unit: FMIN/FMAX/FEQ/FLT/FLE with RISC-V NaN and signed-zero rules.
// One or two register stages behind a single global-advance valid/ready handshake.
module fp_cmp_unit_pipelined #(
    parameter int EXP_W   = 8,
    parameter int MANT_W  = 23,
    parameter int LATENCY = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [EXP_W+MANT_W:0]     operand_A_i,
    input  logic [EXP_W+MANT_W:0]     operand_B_i,
    input  logic [2:0]                operation_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [EXP_W+MANT_W:0]     result_o,
    output logic                      invalid_op_o
);

    localparam int W = 1 + EXP_W + MANT_W;
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         a_nan;
        logic         a_snan;
        logic         b_nan;
        logic         b_snan;
        logic         both_zero;
        logic         lt;
        logic         eq;
    } cls_t;

    // lt is a total order with -0 below +0; zero equality for compares is applied later.
    function automatic cls_t classify(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [2:0] op);
        cls_t c;
        c.a         = a;
        c.b         = b;
        c.op        = op;
        c.a_nan     = (&a[W-2:MANT_W]) && (|a[MANT_W-1:0]);
        c.b_nan     = (&b[W-2:MANT_W]) && (|b[MANT_W-1:0]);
        c.a_snan    = c.a_nan && !a[MANT_W-1];
        c.b_snan    = c.b_nan && !b[MANT_W-1];
        c.both_zero = !(|a[W-2:0]) && !(|b[W-2:0]);
        c.eq        = (a == b);
        if (a[W-1] != b[W-1])
            c.lt = a[W-1];
        else if (a[W-1])
            c.lt = a[W-2:0] > b[W-2:0];
        else
            c.lt = a[W-2:0] < b[W-2:0];
        return c;
    endfunction

    // Returns {invalid flag, result}.
    function automatic logic [W:0] select_result(input cls_t c);
        logic [W-1:0] r;
        logic         nv;
        logic         any_nan;
        logic         any_snan;
        r        = '0;
        nv       = 1'b0;
        any_nan  = c.a_nan || c.b_nan;
        any_snan = c.a_snan || c.b_snan;
        case (c.op)
            3'b000, 3'b001: begin
                nv = any_snan;
                if (c.a_nan && c.b_nan)
                    r = CANON_NAN;
                else if (c.a_nan)
                    r = c.b;
                else if (c.b_nan)
                    r = c.a;
                else if (c.op[0])
                    r = c.lt ? c.b : c.a;
                else
                    r = (c.lt || c.eq) ? c.a : c.b;
            end
            3'b010: begin
                nv   = any_snan;
                r[0] = !any_nan && (c.eq || c.both_zero);
            end
            3'b011: begin
                nv   = any_nan;
                r[0] = !any_nan && c.lt && !c.both_zero;
            end
            3'b100: begin
                nv   = any_nan;
                r[0] = !any_nan && (c.lt || c.eq || c.both_zero);
            end
            default: begin
                r  = '0;
                nv = 1'b0;
            end
        endcase
        return {nv, r};
    endfunction

    logic         adv;
    cls_t         in_cls;
    cls_t         stage_cls;
    logic         stage_valid;
    logic [W:0]   sel;

    always_comb begin
        adv     = !valid_o || ready_i;
        ready_o = adv;
        in_cls  = classify(operand_A_i, operand_B_i, operation_i);
        sel     = select_result(stage_cls);
    end

    generate
        if (LATENCY == 2) begin : g_two
            cls_t s1;
            logic s1_valid;
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    s1       <= '0;
                    s1_valid <= 1'b0;
                end else if (adv) begin
                    s1       <= in_cls;
                    s1_valid <= valid_i;
                end
            end
            assign stage_cls   = s1;
            assign stage_valid = s1_valid;
        end else if (LATENCY == 1) begin : g_one
            assign stage_cls   = in_cls;
            assign stage_valid = valid_i;
        end else begin : g_bad
            $error("fp_cmp_unit_pipelined: LATENCY must be 1 or 2");
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_o      <= 1'b0;
            result_o     <= '0;
            invalid_op_o <= 1'b0;
        end else if (adv) begin
            valid_o      <= stage_valid;
            result_o     <= sel[W-1:0];
            invalid_op_o <= sel[W];
        end
    end

endmodule

// File: doc/fp_cmp_unit_pipelined.md
# fp_cmp_unit_pipelined

Parametrised, pipelined floating-point compare unit. It is the successor to the single-stage FMIN/FMAX magnitude unit. It executes FMIN, FMAX, FEQ, FLT and FLE with RISC-V F-extension NaN and signed-zero semantics. It has a configurable exponent/mantissa width and pipeline depth, and a valid/ready handshake with back-pressure. It sits in the FP execute cluster between the issue stage and the FP writeback/flag merge.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 23, mantissa width. The operand width is W = 1+EXP_W+MANT_W.
- LATENCY, 2, number of pipeline stages. Legal values are 1 or 2. Any other value is an elaboration error.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- valid_i  in  1  input operands and operation are valid.
- ready_o  out  1  unit accepts the input this cycle.
- operand_A_i  in  W  operand A, IEEE layout {sign, exponent, mantissa}.
- operand_B_i  in  W  operand B, same layout.
- operation_i  in  3  000 FMIN, 001 FMAX, 010 FEQ, 011 FLT, 100 FLE; 101–111 reserved.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  W  result value.
- invalid_op_o  out  1  NV exception flag, qualified by valid_o.

## Operation
- Transfer rules: an input transfers when valid_i & ready_o. An output transfers when valid_o & ready_i.
- Global advance: adv = !valid_o | ready_i. ready_o = adv.
- When adv is set, every stage register loads from its predecessor. A stage's valid bit is loaded along with its data.
- When adv is clear, all stages hold.
- Classification (per operand):
  - NaN: exp all-ones, mant ≠ 0.
  - sNaN: NaN with mant MSB = 0.
  - qNaN: NaN with mant MSB = 1.
  - zero: exp = 0, mant = 0.
- Ordering:
  - Non-zero operands are ordered by sign, then by unsigned {exp, mant}. For negative values the magnitude order is reversed.
  - For FEQ/FLT/FLE, +0 and −0 compare equal.
  - For FMIN/FMAX, −0 is ordered below +0: FMIN(+0,−0) = −0 and FMAX(+0,−0) = +0.
  - Subnormals and infinities need no special casing; the ordering rule covers them.
- FMIN/FMAX:
  - Exactly one NaN: the result is the other operand.
  - Both NaN: the result is canonical NaN {0, all-ones exp, 1 followed by zeros}, i.e. 0x7FC00000 at default widths.
  - Otherwise: the lesser operand (FMIN) or the greater operand (FMAX). When A equals B, the result is A.
  - invalid_op_o = either operand is sNaN.
- FEQ/FLT/FLE:
  - result_o = {W-1 zeros, cmp_bit}.
  - Any NaN operand forces cmp_bit = 0.
  - FEQ: invalid_op_o = either operand is sNaN.
  - FLT/FLE: invalid_op_o = either operand is any NaN.
- Reserved operation: result_o = 0, invalid_op_o = 0. The item still flows through the pipeline and produces a valid_o beat.
- Stage split:
  - LATENCY = 2: stage 1 registers the classification, sign/magnitude-compare bits and operands. Stage 2 registers the selected result and flag.
  - LATENCY = 1: everything is computed combinationally and registered once.

## Timing
- Reset (rst_n_i low at a clock edge):
  - All valid bits clear. valid_o = 0.
  - result_o = 0 and invalid_op_o = 0.
  - All stage data registers clear to 0.
  - ready_o = 1 from the first cycle after reset.
- Reset mid-operation flushes every in-flight item. Nothing is emitted after reset.
- Latency: an input accepted at edge n appears with valid_o = 1 after edge n+LATENCY−1 (the data is registered on acceptance). It is visible in the cycle following edge n+LATENCY−1.
- Throughput: one operation per cycle when ready_i = 1.
- Back-pressure:
  - While valid_o & !ready_i: ready_o = 0, and result_o and invalid_op_o are held stable.
  - No item is dropped or duplicated.
  - Pipeline bubbles are not compressed while stalled.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal. ready_o = 1 whenever ready_i = 1.
- result_o and invalid_op_o are don't-care while valid_o = 0, but they must not be X after reset.

## Test plan
- FMIN/FMAX ordering, default widths, LATENCY = 2:
  - FMIN(0x3F800000, 0x40000000) → 0x3F800000, NV = 0, two cycles after acceptance.
  - FMAX(0xBF800000, 0xC0000000) → 0xBF800000.
  - FMIN(0x00000000, 0x80000000) → 0x80000000.
- NaN handling:
  - FMAX(0x7F800001, 0x3F800000) → 0x3F800000, NV = 1.
  - FMIN(0x7FC00001, 0x7FC00002) → 0x7FC00000, NV = 0.
  - FEQ(0x7FC00000, 0x7FC00000) → 0, NV = 0.
  - FLT(0x7FC00000, 0x3F800000) → 0, NV = 1.
- Compares:
  - FLE(0x80000000, 0x00000000) → 1.
  - FLT(0xFF800000, 0x00800000) → 1.
  - FEQ(0x3F800000, 0x3F800000) → 1.
  - Reserved op 111 → result 0, NV = 0, valid_o pulses.
- Back-pressure: stream 8 ops back-to-back. Hold ready_i = 0 for 3 cycles mid-stream. Required: outputs arrive in order with no loss, ready_o = 0 during the stall, and the held output is bit-stable.
- Reset mid-stream: assert rst_n_i low for one cycle with 2 items in flight. Required: valid_o = 0 and result_o = 0 the next cycle, and no flushed item ever appears.
- Parametrisation: EXP_W = 11, MANT_W = 52, LATENCY = 1. FMAX(1.0 = 0x3FF0000000000000, 2.0 = 0x4000000000000000) → 0x4000000000000000 one cycle after acceptance. The canonical NaN at these widths is 0x7FF8000000000000.
